// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the memory responder.
//   mem_size_t    : access size encoding (B/H/W/D = 1/2/4/8 bytes)
//   mem_state_t   : responder FSM states
//   addr_aligned  : natural-alignment check of a byte address for a given size
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'd0,
      MEM_H = 2'd1,
      MEM_W = 2'd2,
      MEM_D = 2'd3
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } mem_state_t;

   // True when the low address bits are a multiple of the access size.
   function automatic logic addr_aligned(input logic [2:0] addr_lo, input mem_size_t size);
      logic ok;
      case (size)
         MEM_B:   ok = 1'b1;
         MEM_H:   ok = (addr_lo[0] == 1'b0);
         MEM_W:   ok = (addr_lo[1:0] == 2'b00);
         MEM_D:   ok = (addr_lo == 3'b000);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the memory responder.
//   size        in   access size (mem_size_t)
//   uns         in   1 = zero-extend loads, 0 = sign-extend (ignored for D)
//   lane        in   byte offset within the 64-bit word (ADDR[2:0])
//   rword       in   current contents of the addressed word
//   wdata       in   right-justified store data
//   load_data   out  extracted and extended load result
//   merged_word out  rword with the store bytes replaced at the lane
module mem_lane_align
   import riscv_mem_pkg::*;
(
   input  mem_size_t   size,
   input  logic        uns,
   input  logic [2:0]  lane,
   input  logic [63:0] rword,
   input  logic [63:0] wdata,
   output logic [63:0] load_data,
   output logic [63:0] merged_word
);

   logic [5:0]  shamt_s;
   logic [63:0] rshift_s;
   logic [63:0] wshift_s;
   logic [7:0]  be_base_s;
   logic [7:0]  be_s;
   logic [63:0] bit_mask_s;

   assign shamt_s = {lane, 3'b000};

   // Load path: bring the addressed lane down to bit 0 and extend it.
   always_comb begin
      rshift_s = rword >> shamt_s;
      case (size)
         MEM_B:   load_data = uns ? {56'd0, rshift_s[7:0]}  : {{56{rshift_s[7]}},  rshift_s[7:0]};
         MEM_H:   load_data = uns ? {48'd0, rshift_s[15:0]} : {{48{rshift_s[15]}}, rshift_s[15:0]};
         MEM_W:   load_data = uns ? {32'd0, rshift_s[31:0]} : {{32{rshift_s[31]}}, rshift_s[31:0]};
         MEM_D:   load_data = rshift_s;
         default: load_data = 64'd0;
      endcase
   end

   // Store path: byte enables for the access, shifted to the lane, expanded to a bit mask.
   always_comb begin
      case (size)
         MEM_B:   be_base_s = 8'h01;
         MEM_H:   be_base_s = 8'h03;
         MEM_W:   be_base_s = 8'h0F;
         MEM_D:   be_base_s = 8'hFF;
         default: be_base_s = 8'h00;
      endcase
      be_s     = be_base_s << lane;
      wshift_s = wdata << shamt_s;
      for (int i = 0; i < 8; i++) begin
         bit_mask_s[i*8 +: 8] = {8{be_s[i]}};
      end
      merged_word = (rword & ~bit_mask_s) | (wshift_s & bit_mask_s);
   end

endmodule

// File: rtl/mem_resp_ctrl.sv
// Memory-side responder for instruction fetch, loads and stores.
// One request at a time over a valid/ready handshake; optional wait states,
// then a single-cycle array access; result held on a valid/ready response.
//   CLK, RESET      clock (rising edge), asynchronous active-high reset
//   REQ_VALID/READY request handshake
//   REQ_WRITE       1 = store, 0 = load
//   REQ_SIZE        0=B 1=H 2=W 3=D
//   REQ_UNSIGNED    zero-extend loads when 1
//   REQ_ADDR        byte address, little-endian
//   REQ_WDATA       right-justified store data
//   RESP_VALID/READY response handshake
//   RESP_RDATA      load result (0 for stores and errors)
//   RESP_ERR        misaligned or out-of-range access
//   BUSY            FSM not in IDLE
module mem_resp_ctrl
   import riscv_mem_pkg::*;
#(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WRITE,
   input  logic [1:0]  REQ_SIZE,
   input  logic        REQ_UNSIGNED,
   input  logic [63:0] REQ_ADDR,
   input  logic [63:0] REQ_WDATA,
   output logic        RESP_VALID,
   input  logic        RESP_READY,
   output logic [63:0] RESP_RDATA,
   output logic        RESP_ERR,
   output logic        BUSY
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   mem_state_t         state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [IDX_W+2:0]   addr_q, addr_d;
   mem_size_t          size_q, size_d;
   logic               write_q, write_d;
   logic               uns_q, uns_d;
   logic [63:0]        wdata_q, wdata_d;
   logic [63:0]        rdata_q, rdata_d;
   logic               err_q, err_d;

   logic [63:0]        mem_q [DEPTH];

   mem_size_t          req_size_s;
   logic               req_err_s;
   logic [IDX_W-1:0]   word_idx_s;
   logic [63:0]        rword_s;
   logic [63:0]        load_data_s;
   logic [63:0]        merged_s;

   assign req_size_s = mem_size_t'(REQ_SIZE);
   // Range check uses the full upper address so aliasing addresses are rejected.
   assign req_err_s  = !addr_aligned(REQ_ADDR[2:0], req_size_s) ||
                       (REQ_ADDR[63:3] >= 61'(DEPTH));
   assign word_idx_s = addr_q[IDX_W+2:3];
   assign rword_s    = mem_q[word_idx_s];

   mem_lane_align u_align (
      .size        (size_q),
      .uns         (uns_q),
      .lane        (addr_q[2:0]),
      .rword       (rword_s),
      .wdata       (wdata_q),
      .load_data   (load_data_s),
      .merged_word (merged_s)
   );

   // Next-state logic: request capture, wait countdown, access result, response handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      size_d  = size_q;
      write_d = write_q;
      uns_d   = uns_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (REQ_VALID) begin
               addr_d  = REQ_ADDR[IDX_W+2:0];
               size_d  = req_size_s;
               write_d = REQ_WRITE;
               uns_d   = REQ_UNSIGNED;
               wdata_d = REQ_WDATA;
               rdata_d = 64'd0;
               if (req_err_s) begin
                  err_d   = 1'b1;
                  state_d = RESP;
               end else if (WAIT_STATES == 32'd0) begin
                  err_d   = 1'b0;
                  state_d = ACCESS;
               end else begin
                  err_d   = 1'b0;
                  cnt_d   = 4'(WAIT_STATES - 32'd1);
                  state_d = WAIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ACCESS: begin
            rdata_d = write_q ? 64'd0 : load_data_s;
            state_d = RESP;
         end
         RESP: begin
            if (RESP_READY) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and captured-request registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         size_q  <= MEM_B;
         write_q <= 1'b0;
         uns_q   <= 1'b0;
         wdata_q <= 64'd0;
         rdata_q <= 64'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         write_q <= write_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Storage array write: contents survive reset; gating on state drops aborted stores.
   always_ff @(posedge CLK) begin
      if (state_q == ACCESS && write_q) begin
         mem_q[word_idx_s] <= merged_s;
      end
   end

   assign REQ_READY  = (state_q == IDLE);
   assign RESP_VALID = (state_q == RESP);
   assign RESP_RDATA = rdata_q;
   assign RESP_ERR   = err_q;
   assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Self-checking bench for mem_resp_ctrl: instance a (WAIT_STATES=1) and
// instance b (WAIT_STATES=0) share request fields and RESP_READY but have
// separate REQ_VALID. Expected responses are queued at issue and popped on response.
module tb_mem_resp_ctrl;

   localparam int unsigned DEPTH = 256;
   localparam int WS_A = 1;
   localparam int WS_B = 0;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_a, req_valid_b;
   logic        req_write, req_unsigned, resp_ready;
   logic [1:0]  req_size;
   logic [63:0] req_addr, req_wdata;

   logic        a_req_ready, a_resp_valid, a_err, a_busy;
   logic [63:0] a_rdata;
   logic        b_req_ready, b_resp_valid, b_err, b_busy;
   logic [63:0] b_rdata;

   int   n_cmp  = 0;
   int   n_fail = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mem_resp_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(WS_A)) dut_a (
      .CLK(clk), .RESET(rst),
      .REQ_VALID(req_valid_a), .REQ_READY(a_req_ready), .REQ_WRITE(req_write),
      .REQ_SIZE(req_size), .REQ_UNSIGNED(req_unsigned), .REQ_ADDR(req_addr),
      .REQ_WDATA(req_wdata), .RESP_VALID(a_resp_valid), .RESP_READY(resp_ready),
      .RESP_RDATA(a_rdata), .RESP_ERR(a_err), .BUSY(a_busy)
   );

   mem_resp_ctrl #(.DEPTH(DEPTH), .WAIT_STATES(WS_B)) dut_b (
      .CLK(clk), .RESET(rst),
      .REQ_VALID(req_valid_b), .REQ_READY(b_req_ready), .REQ_WRITE(req_write),
      .REQ_SIZE(req_size), .REQ_UNSIGNED(req_unsigned), .REQ_ADDR(req_addr),
      .REQ_WDATA(req_wdata), .RESP_VALID(b_resp_valid), .RESP_READY(resp_ready),
      .RESP_RDATA(b_rdata), .RESP_ERR(b_err), .BUSY(b_busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request from a negedge; hold RESP_READY low for 'hold' cycles
   // with junk request pulses, then complete the handshake.
   task automatic do_req(input bit sel, input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] exp_rd, input bit exp_err, input int hold,
                         input string tag);
      exp_t e;
      exp_t got;
      int   lat;
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.lat   = exp_err ? 1 : 2 + (sel ? WS_B : WS_A);
      sb.push_back(e);
      check({tag, "/req_ready_pre"}, 64'(sel ? b_req_ready : a_req_ready), 64'd1);
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      // Scramble request fields after accept; they must have no effect.
      req_addr  = ~addr;
      req_wdata = ~wd;
      req_write = ~wr;
      req_size  = ~sz;
      lat = 1;
      while (!(sel ? b_resp_valid : a_resp_valid) && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      got = sb.pop_front();
      check({tag, "/latency"}, 64'(lat), 64'(got.lat));
      check({tag, "/rdata"}, sel ? b_rdata : a_rdata, got.rdata);
      check({tag, "/err"}, 64'(sel ? b_err : a_err), 64'(got.err));
      for (int i = 0; i < hold; i++) begin
         if (sel) req_valid_b = ~i[0]; else req_valid_a = ~i[0];
         req_addr = 64'h8 + 64'(i);
         @(negedge clk);
         check({tag, "/hold_valid"}, 64'(sel ? b_resp_valid : a_resp_valid), 64'd1);
         check({tag, "/hold_rdata"}, sel ? b_rdata : a_rdata, got.rdata);
         check({tag, "/hold_req_ready"}, 64'(sel ? b_req_ready : a_req_ready), 64'd0);
      end
      req_valid_a = 1'b0;
      req_valid_b = 1'b0;
      resp_ready  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      resp_ready = 1'b0;
      check({tag, "/req_ready_post"}, 64'(sel ? b_req_ready : a_req_ready), 64'd1);
      check({tag, "/resp_valid_post"}, 64'(sel ? b_resp_valid : a_resp_valid), 64'd0);
   endtask

   initial begin
      rst          = 1'b1;
      req_valid_a  = 1'b0;
      req_valid_b  = 1'b0;
      req_write    = 1'b0;
      req_unsigned = 1'b0;
      req_size     = 2'd0;
      req_addr     = 64'd0;
      req_wdata    = 64'd0;
      resp_ready   = 1'b0;
      repeat (2) @(negedge clk);
      check("rst/a_req_ready", 64'(a_req_ready), 64'd1);
      check("rst/a_resp_valid", 64'(a_resp_valid), 64'd0);
      check("rst/a_rdata", a_rdata, 64'd0);
      check("rst/a_err", 64'(a_err), 64'd0);
      check("rst/a_busy", 64'(a_busy), 64'd0);
      check("rst/b_req_ready", 64'(b_req_ready), 64'd1);
      rst = 1'b0;
      @(negedge clk);

      // Doubleword store then load
      do_req(1'b0, 1'b1, 2'd3, 1'b0, 64'h10, 64'h1122334455667788, 64'd0, 1'b0, 0, "sd10");
      do_req(1'b0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 64'h1122334455667788, 1'b0, 0, "ld10");
      // Byte store into lane 3, signed/unsigned byte loads, word merge
      do_req(1'b0, 1'b1, 2'd0, 1'b0, 64'h13, 64'h80, 64'd0, 1'b0, 0, "sb13");
      do_req(1'b0, 1'b0, 2'd0, 1'b0, 64'h13, 64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0, 0, "lb13");
      do_req(1'b0, 1'b0, 2'd0, 1'b1, 64'h13, 64'd0, 64'h0000000000000080, 1'b0, 0, "lbu13");
      do_req(1'b0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 64'h1122334480667788, 1'b0, 0, "ld10_merged");
      // Errors: misaligned and out of range; array untouched
      do_req(1'b0, 1'b0, 2'd2, 1'b0, 64'h12, 64'd0, 64'd0, 1'b1, 0, "lw12_misalign");
      do_req(1'b0, 1'b1, 2'd1, 1'b0, 64'h11, 64'hFFFF, 64'd0, 1'b1, 0, "sh11_misalign");
      do_req(1'b0, 1'b0, 2'd3, 1'b0, 64'h10, 64'd0, 64'h1122334480667788, 1'b0, 0, "ld10_unchanged");
      do_req(1'b0, 1'b0, 2'd3, 1'b0, 64'(8 * DEPTH), 64'd0, 64'd0, 1'b1, 0, "ld_oor");
      // Last valid word
      do_req(1'b0, 1'b1, 2'd3, 1'b0, 64'(8 * (DEPTH - 1)), 64'hA5A55A5A0F0FF0F0, 64'd0, 1'b0, 0, "sd_last");
      do_req(1'b0, 1'b0, 2'd3, 1'b0, 64'(8 * (DEPTH - 1)), 64'd0, 64'hA5A55A5A0F0FF0F0, 1'b0, 0, "ld_last");
      // Halfword load with response back-pressure
      do_req(1'b0, 1'b0, 2'd1, 1'b0, 64'h16, 64'd0, 64'h0000000000001122, 1'b0, 5, "lh16_hold");

      // Reset during WAIT drops the pending store
      do_req(1'b0, 1'b1, 2'd3, 1'b0, 64'h20, 64'h0123456789ABCDEF, 64'd0, 1'b0, 0, "sd20_prior");
      check("rst_mid/req_ready_pre", 64'(a_req_ready), 64'd1);
      req_write    = 1'b1;
      req_size     = 2'd3;
      req_unsigned = 1'b0;
      req_addr     = 64'h20;
      req_wdata    = 64'hDEAD;
      req_valid_a  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid_a = 1'b0;
      check("rst_mid/busy_wait", 64'(a_busy), 64'd1);
      rst = 1'b1;
      #1;
      check("rst_mid/req_ready", 64'(a_req_ready), 64'd1);
      check("rst_mid/resp_valid", 64'(a_resp_valid), 64'd0);
      check("rst_mid/rdata", a_rdata, 64'd0);
      check("rst_mid/err", 64'(a_err), 64'd0);
      check("rst_mid/busy", 64'(a_busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid/req_ready_after", 64'(a_req_ready), 64'd1);
      do_req(1'b0, 1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 64'h0123456789ABCDEF, 1'b0, 0, "ld20_after_rst");

      // Zero-wait-state instance: back-to-back word store and loads
      do_req(1'b1, 1'b1, 2'd2, 1'b0, 64'h40, 64'hCAFEBABE, 64'd0, 1'b0, 0, "b_sw40");
      do_req(1'b1, 1'b0, 2'd2, 1'b0, 64'h40, 64'd0, 64'hFFFFFFFFCAFEBABE, 1'b0, 0, "b_lw40");
      do_req(1'b1, 1'b0, 2'd2, 1'b1, 64'h40, 64'd0, 64'h00000000CAFEBABE, 1'b0, 0, "b_lwu40");
      do_req(1'b1, 1'b0, 2'd1, 1'b0, 64'h42, 64'd0, 64'hFFFFFFFFFFFFCAFE, 1'b0, 0, "b_lh42");
      do_req(1'b1, 1'b0, 2'd3, 1'b0, 64'h44, 64'd0, 64'd0, 1'b1, 0, "b_ld44_misalign");

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
